// File: rtl/demux_dispatch_pkg.sv
// Shared constants and types for the result demux dispatch controller.
// The optional delivery counters are enabled with the DEMUX_DISPATCH_CNT_EN macro.
package demux_dispatch_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_ALT    = 1'b1;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/demux_dispatch_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// The head entry is visible combinationally so the controller can load it in the same cycle it pops.
module demux_dispatch_fifo
    import demux_dispatch_pkg::*;
#(
    parameter int unsigned W     = 17,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
        $error("demux_dispatch_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;

    always_comb begin
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Flags are decoded from the next count so they come straight out of flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller for the 1-to-2 result demux: FIFO, selection, single-word output stage.
// Define DEMUX_DISPATCH_CNT_EN to add saturating per-channel delivery counters (cnt0/cnt1/cnt_clr).
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dest,
    output logic              in_ready,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out0_data,
    input  logic              out0_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
`ifdef DEMUX_DISPATCH_CNT_EN
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
`endif
    output logic              busy
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("demux_dispatch_ctrl: CNT_W must be at least 1");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sel_q, sel_d;
    logic              rr_q, rr_d;
    logic [DATA_W:0]   fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              sel_ready;
    logic              hs;
    logic              load;

    demux_dispatch_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata ({in_dest, in_data}),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sel_ready = sel_q ? out1_ready : out0_ready;
    assign hs        = (state_q == ST_SEND) && sel_ready;
    // A load refills the output stage whenever it is empty or being emptied this cycle.
    assign load      = !fifo_empty && ((state_q == ST_IDLE) || sel_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!fifo_empty) state_d = ST_SEND;
            ST_SEND: if (sel_ready && fifo_empty) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        sel_d  = sel_q;
        rr_d   = rr_q;
        if (load) begin
            data_d = fifo_rdata[DATA_W-1:0];
            sel_d  = (mode == MODE_ALT) ? rr_q : fifo_rdata[DATA_W];
            if (mode == MODE_ALT) rr_d = !rr_q;
        end
    end

    always_comb begin
        out0_valid = (state_q == ST_SEND) && !sel_q;
        out1_valid = (state_q == ST_SEND) && sel_q;
        out0_data  = out0_valid ? data_q : '0;
        out1_data  = out1_valid ? data_q : '0;
        in_ready   = !fifo_full;
        busy       = !fifo_empty || (state_q == ST_SEND);
    end

`ifdef DEMUX_DISPATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        always_comb begin
            cnt_d[gi] = cnt_q[gi];
            if (cnt_clr) begin
                cnt_d[gi] = '0;
            end else if (hs && (sel_q == 1'(gi)) && (cnt_q[gi] != '1)) begin
                cnt_d[gi] = cnt_q[gi] + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q[gi] <= '0;
            else     cnt_q[gi] <= cnt_d[gi];
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Randomized bench for demux_dispatch_ctrl against a queue-based transaction model.
// Counter ports are exercised when DEMUX_DISPATCH_CNT_EN is defined.
module tb_demux_dispatch_ctrl;

    localparam int DW       = 16;
    localparam int DEPTH    = 2;
    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_dest = 1'b0;
    logic          in_ready;
    logic          out0_valid, out1_valid;
    logic [DW-1:0] out0_data, out1_data;
    logic          out0_ready = 1'b0;
    logic          out1_ready = 1'b0;
    logic          busy;
    logic          cnt_clr = 1'b0;
`ifdef DEMUX_DISPATCH_CNT_EN
    logic [TB_CNT_W-1:0] cnt0, cnt1;
`endif

    demux_dispatch_ctrl #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_ready   (in_ready),
        .out0_valid (out0_valid),
        .out0_data  (out0_data),
        .out0_ready (out0_ready),
        .out1_valid (out1_valid),
        .out1_data  (out1_data),
        .out1_ready (out1_ready),
`ifdef DEMUX_DISPATCH_CNT_EN
        .cnt_clr    (cnt_clr),
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Transaction model: queued words, the one word on offer, round-robin bit.
    logic [DW:0]   mq[$];
    logic          held_v = 1'b0;
    logic          held_sel = 1'b0;
    logic [DW-1:0] held_data = '0;
    logic          rr = 1'b0;
    int            mcnt[2] = '{0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out0_valid", 32'(out0_valid), 32'(held_v && !held_sel));
        chk("out0_data",  32'(out0_data),  (held_v && !held_sel) ? 32'(held_data) : 32'd0);
        chk("out1_valid", 32'(out1_valid), 32'(held_v && held_sel));
        chk("out1_data",  32'(out1_data),  (held_v && held_sel) ? 32'(held_data) : 32'd0);
        chk("in_ready",   32'(in_ready),   32'(mq.size() < DEPTH));
        chk("busy",       32'(busy),       32'((mq.size() != 0) || held_v));
`ifdef DEMUX_DISPATCH_CNT_EN
        chk("cnt0", 32'(cnt0), 32'(mcnt[0]));
        chk("cnt1", 32'(cnt1), 32'(mcnt[1]));
`endif
    endtask

    // Called at a falling edge: check, drive inputs, advance the model across one rising edge.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ds, input logic md,
                        input logic r0, input logic r1, input logic cc);
        logic        hs;
        logic        pushing;
        logic [DW:0] e;
        check_outputs();
        in_valid = iv; in_data = d; in_dest = ds; mode = md;
        out0_ready = r0; out1_ready = r1; cnt_clr = cc;
        hs      = held_v && (held_sel ? r1 : r0);
        pushing = iv && (mq.size() < DEPTH);
        if (hs) $display("deliver ch%0d data %0d", held_sel, held_data);
`ifdef DEMUX_DISPATCH_CNT_EN
        if (cc) mcnt = '{0, 0};
        else if (hs && mcnt[held_sel] < CNT_MAX) mcnt[held_sel]++;
`endif
        if ((!held_v || hs) && mq.size() > 0) begin
            e         = mq.pop_front();
            held_v    = 1'b1;
            held_data = e[DW-1:0];
            held_sel  = md ? rr : e[DW];
            if (md) rr = ~rr;
        end else if (hs) begin
            held_v = 1'b0;
        end
        if (pushing) mq.push_back({ds, d});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic md, input logic r0, input logic r1);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, md, r0, r1, 1'b0);
    endtask

    // Asserts reset between clock edges and checks that outputs clear without waiting for a clock.
    task automatic async_reset();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out0_data",  32'(out0_data),  32'd0);
        chk("rst_out1_data",  32'(out1_data),  32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        mq.delete();
        held_v = 1'b0; held_sel = 1'b0; held_data = '0; rr = 1'b0; mcnt = '{0, 0};
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic md;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Direct routing: 100 to out0, 200 to out1.
        step(1'b1, 16'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'd200, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b0, 1'b1, 1'b1);

        // Alternate routing ignores in_dest.
        for (int i = 1; i <= 4; i++) step(1'b1, 16'(100 * i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b1, 1'b1);

        // Backpressure on out0, then release.
        for (int i = 3; i <= 5; i++) step(1'b1, 16'(100 * i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b0, 1'b1, 1'b1);

        // Reset with two words queued and one held.
        for (int i = 6; i <= 8; i++) step(1'b1, 16'(100 * i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        async_reset();
        idle(3, 1'b0, 1'b1, 1'b1);

`ifdef DEMUX_DISPATCH_CNT_EN
        // Five words to out1 saturate the counter, then a clear during a handshake.
        for (int i = 0; i < 5; i++) step(1'b1, 16'(i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b0, 1'b1, 1'b1);
`endif

        md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) md = ~md;
            step($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom), md,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 31) == 0);
            if ($urandom_range(0, 499) == 0) async_reset();
        end
        idle(4, md, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
